// File: rtl/npu_spi_tx_if.sv
//-----------------------------------------------------------------------------
// npu_spi_tx_if
// Groups the request side and the SPI pin side of the NPU SPI transmitter.
//
// Handshake: start_transmission is a one-cycle request. It is accepted only
// when busy is low (transmitter idle); tx_data is sampled in that same cycle.
// Requests seen while busy is high are dropped, never queued. Completion is
// signalled by a one-cycle spi_16_bit_transmitted pulse, accompanied by
// all_transmitted on the last word of a result set.
//
// Signals:
//   start_transmission      requester -> tx  one-cycle send request
//   tx_data                 requester -> tx  word to send
//   spi_sclk/mosi/cs_n      tx -> pins       SPI mode 0 bus
//   spi_16_bit_transmitted  tx -> requester  frame done pulse
//   all_transmitted         tx -> requester  last-word done pulse
//   busy                    tx -> requester  frame in progress
//   tx_word_idx             tx -> requester  index of next word to send
//   state_dbg               tx -> observer   current FSM state encoding
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface npu_spi_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
);
  logic                  start_transmission;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_cs_n;
  logic                  spi_16_bit_transmitted;
  logic                  all_transmitted;
  logic                  busy;
  logic [IDX_WIDTH-1:0]  tx_word_idx;
  logic [1:0]            state_dbg;

  modport master (
    output start_transmission, tx_data,
    input  spi_sclk, spi_mosi, spi_cs_n, spi_16_bit_transmitted,
           all_transmitted, busy, tx_word_idx, state_dbg
  );

  modport slave (
    input  start_transmission, tx_data,
    output spi_sclk, spi_mosi, spi_cs_n, spi_16_bit_transmitted,
           all_transmitted, busy, tx_word_idx, state_dbg
  );
endinterface

// File: rtl/npu_spi_tx.sv
//-----------------------------------------------------------------------------
// npu_spi_tx
// Serializes NPU result words onto an SPI mode 0 bus, MSB first. Each
// accepted request sends one DATA_WIDTH-bit frame; each SCLK half-period
// lasts CLK_DIV system clocks. A word index counts frames modulo NUM_WORDS
// and selects the next result word externally.
//
// Ports:
//   clk      system clock
//   reset_b  asynchronous active-low reset (aborts any frame in flight)
//   bus      npu_spi_tx_if.slave: request, SPI pins, status, state_dbg
//
// All bus outputs are registered; each is computed from the next state so
// the pins change in the same cycle the FSM enters a state.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module npu_spi_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int NUM_WORDS  = 10,
  parameter int IDX_WIDTH  = 4
) (
  input logic         clk,
  input logic         reset_b,
  npu_spi_tx_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  all_q, all_d;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      all_q   <= all_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (bus.start_transmission) begin
          state_d = SHIFT_LO;
          shift_d = bus.tx_data;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            // Next bit moves into the MSB as SCLK falls.
            shift_d = shift_q << 1;
            bit_d   = bit_q + BIT_W'(1);
            state_d = SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs are derived from the upcoming state.
    cs_n_d = !((state_d == SHIFT_LO) || (state_d == SHIFT_HI));
    sclk_d = (state_d == SHIFT_HI);
    mosi_d = cs_n_d ? 1'b0 : shift_d[DATA_WIDTH-1];
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    // idx_q still holds this frame's index when DONE is being entered.
    all_d  = (state_d == DONE) && (idx_q == IDX_LAST);
  end

  assign bus.spi_cs_n               = cs_n_q;
  assign bus.spi_sclk               = sclk_q;
  assign bus.spi_mosi               = mosi_q;
  assign bus.busy                   = busy_q;
  assign bus.spi_16_bit_transmitted = done_q;
  assign bus.all_transmitted        = all_q;
  assign bus.tx_word_idx            = idx_q;
  assign bus.state_dbg              = state_q;

endmodule
